bus_uart_tx: RTL and testbench
==============================

BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_2000, meaning the 16-byte-aligned base address of the register window.
REQ-002 SHALL have parameter DIV_RESET, default 16'd103, meaning the reset value of the DIV register (bit period = DIV+1 clk cycles).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the TX FIFO entry count (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning the synchronous active-low reset.
REQ-006 SHALL have port addr, input, 32, meaning the byte address from the bus hub device port.
REQ-007 SHALL have port wdata, input, 32, meaning the write data.
REQ-008 SHALL have port wmask, input, 4, meaning the byte-lane write enables.
REQ-009 SHALL have port wen, input, 1, meaning the write strobe.
REQ-010 SHALL have port ren, input, 1, meaning the read strobe.
REQ-011 SHALL have port rdata, output, 32, meaning the read data, valid while done=1.
REQ-012 SHALL have port done, output, 1, meaning the one-cycle transfer-complete pulse.
REQ-013 SHALL have port active, output, 1, meaning the combinational address-decode hit.
REQ-014 SHALL have port tx, output, 1, meaning the serial line, idle high.

Function
REQ-015 SHALL drive active = (addr[31:4] == BASE_ADDR[31:4]), purely combinational.
REQ-016 SHALL accept a request when (wen|ren) & active & !done, and SHALL register done=1 for exactly one cycle on the following edge.
REQ-017 SHALL deassert done in all other cycles; the hub drops its strobes in the cycle done=1, so a held strobe never double-accepts.
REQ-018 SHALL decode register offset 0x0 TXDATA: a write with wmask[0]=1 pushes wdata[7:0]; a read returns 0.
REQ-019 SHALL decode register offset 0x4 STATUS: a read returns {29'b0, overflow, full, busy}; a write with wmask[0]=1 and wdata[2]=1 clears overflow.
REQ-020 SHALL decode register offset 0x8 DIV: a read returns {16'b0, div}; wmask[0] and wmask[1] write div[7:0] and div[15:8] respectively.
REQ-021 SHALL return rdata=0 for offset 0xC and SHALL ignore writes to it; rdata SHALL be 0 whenever done=0.
REQ-022 SHALL evaluate the FIFO full condition from the registered count before any same-cycle pop; a push while full is dropped and sets the sticky overflow flag.
REQ-023 SHALL define busy = (state != IDLE) | (FIFO not empty), and full = (count == FIFO_DEPTH).
REQ-024 SHALL implement transmitter states IDLE, START, DATA, STOP, sending 8N1 frames LSB first.
REQ-025 In IDLE with the FIFO non-empty, SHALL pop one byte, enter START and drive tx=0 on the same edge.
REQ-026 SHALL hold each bit for exactly div+1 cycles using a down-counter reloaded from div at every bit boundary.
REQ-027 SHALL make a DIV write take effect at the next bit boundary only, never truncating the current bit.
REQ-028 SHALL step START->DATA, then DATA for 8 bits, then STOP (tx=1, one bit period).
REQ-029 At the end of STOP, SHALL enter START directly if the FIFO is non-empty (no idle gap), else enter IDLE.
REQ-030 SHALL write each FIFO entry at the write pointer and advance the pointer on push; pointers wrap modulo FIFO_DEPTH.
REQ-031 SHALL service a push and a pop in the same cycle (FIFO not full) with the count left unchanged.

Reset
REQ-032 While rst=0 at a clock edge, SHALL set tx=1, done=0, rdata=0, state=IDLE, FIFO empty (pointers and count 0), overflow=0, div=DIV_RESET, and bit counter 0.
REQ-033 A reset asserted mid-frame SHALL abort the frame, with tx=1 on the next edge and queued bytes discarded.

Verification
REQ-034 Bench SHALL cover: after reset, read 0x8 -> rdata=103 and done high for 1 cycle; read 0x4 -> 0.
REQ-035 Bench SHALL cover: write DIV=3, then TXDATA=0xA5 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; busy=0 after 40 cycles.
REQ-036 Bench SHALL cover: DIV=3, three bytes 0x01,0x02,0x03 back-to-back -> 120 cycles of contiguous frames with no idle gap between stop and start.
REQ-037 Bench SHALL cover: DIV=100, 9 writes while the first frame is active -> first byte popped, 8 queued; a 10th write sets overflow; STATUS reads 0x7; writing 0x4 to STATUS clears it to 0x3.
REQ-038 Bench SHALL cover: write DIV=7 during a DATA bit at DIV=3 -> current bit stays 4 cycles; next bit lasts 8 cycles.
REQ-039 Bench SHALL cover: rst=0 mid-DATA with 3 bytes queued -> tx=1 on the next edge; after release, STATUS reads 0 and tx stays idle.

Source files
------------

// File: rtl/bus_uart_tx.sv
// Bus-mapped UART transmitter: TXDATA/STATUS/DIV register window feeding a byte
// FIFO that drives an 8N1 serial line, LSB first, with a programmable bit period.
module bus_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter logic [15:0] DIV_RESET  = 16'd103,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        done,
  output logic        active,
  output logic        tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [15:0]       div_q, div_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  logic        accept, full, empty, busy, push, pop;
  logic [31:0] read_val;
  logic        unused_bits;

  assign unused_bits = ^{addr[1:0], wdata[31:16], wmask[3:2]};

  assign active = (addr[31:4] == BASE_ADDR[31:4]);
  assign accept = (wen | ren) & active & ~done_q;
  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign busy   = (state_q != IDLE) | ~empty;

  // Register decode; full is taken from the registered count, ahead of any pop this cycle
  always_comb begin
    read_val = '0;
    case (addr[3:2])
      2'd1:    read_val = {29'b0, ovf_q, full, busy};
      2'd2:    read_val = {16'b0, div_q};
      default: read_val = '0;
    endcase
    done_d  = accept;
    rdata_d = (accept & ren) ? read_val : '0;
    push    = 1'b0;
    ovf_d   = ovf_q;
    div_d   = div_q;
    if (accept & wen) begin
      case (addr[3:2])
        2'd0: begin
          if (wmask[0]) begin
            if (full) ovf_d = 1'b1;
            else      push  = 1'b1;
          end
        end
        2'd1: begin
          if (wmask[0] & wdata[2]) ovf_d = 1'b0;
        end
        2'd2: begin
          if (wmask[0]) div_d[7:0]  = wdata[7:0];
          if (wmask[1]) div_d[15:8] = wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  // Bit timer reloads from div only at bit boundaries, so a DIV write never cuts a bit short
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    if (state_q == IDLE) begin
      if (!empty) begin
        pop       = 1'b1;
        state_d   = START;
        tx_d      = 1'b0;
        bit_cnt_d = div_q;
        shift_d   = fifo_mem[rptr_q];
      end
    end else if (bit_cnt_q != '0) begin
      bit_cnt_d = bit_cnt_q - 16'd1;
    end else begin
      bit_cnt_d = div_q;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
            shift_d   = shift_q >> 1;
          end
        end
        STOP: begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
            shift_d = fifo_mem[rptr_q];
          end else begin
            state_d   = IDLE;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_q     <= DIV_RESET;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) fifo_mem[wptr_q] <= wdata[7:0];
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign tx    = tx_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Bench for bus_uart_tx: directed register/line scenarios plus random bus traffic,
// compared cycle by cycle against a queue-based frame model of the serial line.
module tb_bus_uart_tx;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          DEPTH = 8;
  localparam int          HMAX  = 40000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic        wen, ren;
  logic [31:0] rdata;
  logic        done, active, tx;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  bus_uart_tx #(.BASE_ADDR(BASE), .DIV_RESET(16'd103), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wmask(wmask),
    .wen(wen), .ren(ren), .rdata(rdata), .done(done), .active(active), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: FIFO of bytes, pending frame bit levels, and per-cycle line levels
  logic [15:0] m_div;
  logic [7:0]  m_fifo[$];
  bit          m_bits[$];
  bit          m_wave[$];
  bit          m_ovf, m_busy, m_done, m_rd_op, m_from_frame, m_tx;
  logic [31:0] m_rdata;
  int          cyc = 0;
  bit          hist [HMAX];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[3:2])
      2'd1:    return {29'b0, m_ovf, (m_fifo.size() == DEPTH), m_busy};
      2'd2:    return {16'b0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit frame_level(input logic [7:0] b, input int k, input int div);
    int bitn;
    bitn = k / (div + 1);
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit          acc, full_pre, lvl;
    logic [15:0] div_pre;
    logic [7:0]  b;
    cyc++;
    if (!rst) begin
      m_div = 16'd103;
      m_fifo.delete(); m_bits.delete(); m_wave.delete();
      m_ovf = 0; m_busy = 0; m_done = 0; m_rd_op = 0; m_from_frame = 0;
      m_rdata = 32'd0; m_tx = 1'b1;
    end else begin
      acc      = (wen || ren) && (addr[31:4] == BASE[31:4]) && !m_done;
      full_pre = (m_fifo.size() == DEPTH);
      div_pre  = m_div;
      m_rdata  = (acc && ren) ? model_read(addr) : 32'd0;
      m_rd_op  = acc && ren;
      m_done   = acc;
      if (m_wave.size() == 0) begin
        if (m_bits.size() == 0 && m_fifo.size() != 0) begin
          b = m_fifo.pop_front();
          m_bits.push_back(1'b0);
          for (int i = 0; i < 8; i++) m_bits.push_back(b[i]);
          m_bits.push_back(1'b1);
        end
        if (m_bits.size() != 0) begin
          lvl = m_bits.pop_front();
          for (int i = 0; i <= int'(div_pre); i++) m_wave.push_back(lvl);
        end
      end
      if (m_wave.size() != 0) begin
        m_tx = m_wave.pop_front();
        m_from_frame = 1'b1;
      end else begin
        m_tx = 1'b1;
        m_from_frame = 1'b0;
      end
      if (acc && wen) begin
        case (addr[3:2])
          2'd0: if (wmask[0]) begin
                  if (full_pre) m_ovf = 1'b1;
                  else          m_fifo.push_back(wdata[7:0]);
                end
          2'd1: if (wmask[0] && wdata[2]) m_ovf = 1'b0;
          2'd2: begin
                  if (wmask[0]) m_div[7:0]  = wdata[7:0];
                  if (wmask[1]) m_div[15:8] = wdata[15:8];
                end
          default: ;
        endcase
      end
      m_busy = m_from_frame || (m_fifo.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (cyc < HMAX) hist[cyc] = tx;
    if (chk_en) begin
      check_eq("tx", 32'(tx), 32'(m_tx));
      check_eq("done", 32'(done), 32'(m_done));
      if (!m_done || m_rd_op) check_eq("rdata", rdata, m_rdata);
      check_eq("active", 32'(active), 32'(addr[31:4] == BASE[31:4]));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output logic [31:0] rd);
    int n;
    addr = a; wdata = d; wmask = m; wen = wr; ren = ~wr;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done && n < 6);
    check_eq("bus_done", 32'(done), 32'd1);
    rd = rdata;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] dummy;
    bus_op(1'b1, BASE + 32'(off), d, m, dummy);
  endtask

  task automatic rd_reg(input logic [3:0] off, output logic [31:0] rd);
    bus_op(1'b0, BASE + 32'(off), 32'd0, 4'd0, rd);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    idle(n);
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int c0, c1, sel, n;
    rst = 1'b0; wen = 1'b0; ren = 1'b0;
    addr = BASE; wdata = 32'd0; wmask = 4'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst = 1'b1;

    rd_reg(4'h8, rd);
    check_eq("div_reset", rd, 32'd103);
    idle(1);
    check_eq("done_pulse", 32'(done), 32'd0);
    rd_reg(4'h4, rd);
    check_eq("status_reset", rd, 32'd0);

    // Single frame 0xA5 at DIV=3
    wr_reg(4'h8, 32'd3, 4'b0011);
    wr_reg(4'h0, 32'hA5, 4'b0001);
    c0 = cyc;
    idle(42);
    for (int k = 0; k < 40; k++)
      check_eq("frame_a5", 32'(hist[c0+1+k]), 32'(frame_level(8'hA5, k, 3)));
    check_eq("a5_idle", 32'(hist[c0+41]), 32'd1);
    rd_reg(4'h4, rd);
    check_eq("a5_not_busy", rd, 32'd0);

    // Three back-to-back frames, no gap
    wr_reg(4'h0, 32'h01, 4'b0001);
    c0 = cyc;
    wr_reg(4'h0, 32'h02, 4'b0001);
    wr_reg(4'h0, 32'h03, 4'b0001);
    idle(125);
    for (int k = 0; k < 120; k++)
      check_eq("frames3", 32'(hist[c0+1+k]), 32'(frame_level(8'(k/40 + 1), k % 40, 3)));
    check_eq("frames3_idle", 32'(hist[c0+121]), 32'd1);

    // FIFO fill and overflow at DIV=100
    wr_reg(4'h8, 32'd100, 4'b0011);
    for (int i = 0; i < 9; i++) wr_reg(4'h0, 32'($urandom_range(0, 255)), 4'b0001);
    rd_reg(4'h4, rd);
    check_eq("status_full", rd, 32'h3);
    wr_reg(4'h0, 32'h5A, 4'b0001);
    rd_reg(4'h4, rd);
    check_eq("status_ovf", rd, 32'h7);
    wr_reg(4'h4, 32'h4, 4'b0001);
    rd_reg(4'h4, rd);
    check_eq("status_ovf_clr", rd, 32'h3);
    apply_reset(2);
    rd_reg(4'h8, rd);
    check_eq("div_after_rst", rd, 32'd103);

    // DIV change mid-bit, then reset mid-frame with bytes queued
    wr_reg(4'h8, 32'd3, 4'b0011);
    wr_reg(4'h0, 32'h55, 4'b0001);
    c0 = cyc;
    idle(5);
    wr_reg(4'h8, 32'd7, 4'b0011);
    for (int i = 0; i < 3; i++) wr_reg(4'h0, 32'(8'h10 + i), 4'b0001);
    idle(14);
    check_eq("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b0;
    idle(1);
    check_eq("rst_abort_tx", 32'(tx), 32'd1);
    idle(1);
    rst = 1'b1;
    check_eq("divchg_start", 32'(hist[c0+4]), 32'd0);
    for (int k = 5; k <= 26; k++)
      check_eq("divchg_bits", 32'(hist[c0+k]),
               32'((k <= 8) ? 1 : (k <= 16) ? 0 : (k <= 24) ? 1 : 0));
    rd_reg(4'h4, rd);
    check_eq("status_after_abort", rd, 32'd0);
    c1 = cyc;
    idle(31);
    for (int k = 1; k <= 30; k++)
      check_eq("idle_after_abort", 32'(hist[c1+k]), 32'd1);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: wr_reg(4'h0, 32'($urandom_range(0, 255)),
                           {3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) != 0)});
        4: rd_reg(4'(4 * $urandom_range(0, 3)), rd);
        5: wr_reg(4'h8, 32'($urandom_range(0, 4)), 4'($urandom_range(0, 15)));
        6: wr_reg(4'h4, 32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        7: wr_reg(4'hC, $urandom, 4'($urandom_range(0, 15)));
        8: begin
             addr = BASE + 32'h10 * 32'($urandom_range(1, 64)) + 32'(4 * $urandom_range(0, 3));
             wdata = $urandom; wmask = 4'hF;
             if ($urandom_range(0, 1) == 1) wen = 1'b1; else ren = 1'b1;
             idle(1);
             wen = 1'b0; ren = 1'b0; addr = BASE;
             idle(1);
           end
        default: begin
             if ($urandom_range(0, 19) == 0) apply_reset($urandom_range(1, 3));
             else idle($urandom_range(1, 30));
           end
      endcase
    end
    n = 0;
    while (m_busy && n < 3000) begin idle(1); n++; end
    idle(2);
    rd_reg(4'h4, rd);
    check_eq("drain_busy", 32'(rd[0]), 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
